// File: rtl/dma_controller.sv
// Bus-master DMA engine: catches the device's data-ready interrupt, asks the
// CPU for a destination address, arbitrates for the memory bus and copies
// NUM_CHUNKS device chunks into consecutive memory locations.
module dma_controller #(
    parameter int WORD_SIZE   = 16,
    parameter int CHUNK_WORDS = 4,
    parameter int NUM_CHUNKS  = 3,
    parameter int MEM_LATENCY = 4
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               dev_interrupt,
    output wire  [1:0]                         dev_offset,
    input  logic [CHUNK_WORDS*WORD_SIZE-1:0]   dev_data,
    output wire                                dma_req,
    input  logic                               cmd_valid,
    input  logic [WORD_SIZE-1:0]               cmd_addr,
    output wire                                cmd_ready,
    output wire                                br,
    input  logic                               bg,
    output wire  [WORD_SIZE-1:0]               mem_addr,
    output wire  [CHUNK_WORDS*WORD_SIZE-1:0]   mem_data,
    output wire                                mem_write,
    output wire                                dma_done
);

    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_PENDING = 3'd1;
    localparam logic [2:0] ST_REQ     = 3'd2;
    localparam logic [2:0] ST_WRITE   = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    logic [2:0]           state_q, state_d;
    logic                 irq_q;
    logic [1:0]           chunk_q, chunk_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WORD_SIZE-1:0] base_q, base_d;

    logic                 irq_rise;
    logic                 cnt_last;
    logic                 chunk_last;
    logic                 writing;
    logic [WORD_SIZE-1:0] chunk_addr;

    assign irq_rise   = dev_interrupt & ~irq_q;
    assign cnt_last   = (cnt_q == CNT_W'(MEM_LATENCY - 1));
    assign chunk_last = (chunk_q == 2'(NUM_CHUNKS - 1));
    assign writing    = (state_q == ST_WRITE);
    // Address arithmetic wraps at the top of the word address space.
    assign chunk_addr = base_q + WORD_SIZE'(CHUNK_WORDS * int'(chunk_q));

    // Next-state and datapath decisions for the transfer sequencer.
    always_comb begin
        state_d = state_q;
        chunk_d = chunk_q;
        cnt_d   = cnt_q;
        base_d  = base_q;
        case (state_q)
            ST_IDLE: begin
                if (irq_rise) state_d = ST_PENDING;
            end
            ST_PENDING: begin
                if (cmd_valid) begin
                    base_d  = cmd_addr;
                    chunk_d = '0;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bg) begin
                    cnt_d   = '0;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                // Losing the grant wins over finishing a chunk: the chunk is
                // replayed from its first cycle once the bus comes back.
                if (!bg) begin
                    cnt_d   = '0;
                    state_d = ST_REQ;
                end else if (cnt_last) begin
                    if (chunk_last) begin
                        state_d = ST_DONE;
                    end else begin
                        chunk_d = chunk_q + 2'd1;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset abandons any transfer immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            irq_q   <= 1'b0;
            chunk_q <= '0;
            cnt_q   <= '0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            irq_q   <= dev_interrupt;
            chunk_q <= chunk_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
        end
    end

    // Control outputs are decoded purely from the registered state.
    assign dma_req    = (state_q == ST_PENDING);
    assign cmd_ready  = (state_q == ST_PENDING);
    assign br         = (state_q == ST_REQ) || writing;
    assign dma_done   = (state_q == ST_DONE);
    // Offset 3 is never a valid chunk, so the device floats its data bus.
    assign dev_offset = writing ? chunk_q : 2'b11;

    // Memory bus is only driven while this engine owns it.
    assign mem_addr  = writing ? chunk_addr : {WORD_SIZE{1'bz}};
    assign mem_write = writing ? 1'b1 : 1'bz;

    genvar gi;
    generate
        for (gi = 0; gi < CHUNK_WORDS; gi++) begin : g_data_word
            assign mem_data[gi*WORD_SIZE +: WORD_SIZE] =
                writing ? dev_data[gi*WORD_SIZE +: WORD_SIZE] : {WORD_SIZE{1'bz}};
        end
    endgenerate

endmodule

// File: tb/tb_dma_controller.sv
// Randomised scoreboard bench for dma_controller: the stimulus side pushes the
// expected memory writes of each transfer, a monitor pops them as writes appear.
module tb_dma_controller;

    logic        clk = 1'b0;
    logic        clk_en = 1'b0;
    logic        reset_n = 1'b1;
    logic        dev_interrupt = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [15:0] cmd_addr = 16'h0;
    logic        bg = 1'b0;

    wire  [1:0]  dev_offset;
    wire  [63:0] dev_data;
    wire         dma_req;
    wire         cmd_ready;
    wire         br;
    wire  [15:0] mem_addr;
    wire  [63:0] mem_data;
    wire         mem_write;
    wire         dma_done;

    logic [63:0] storage [0:3];

    typedef struct {
        logic [15:0] addr;
        logic [63:0] data;
        logic [1:0]  chunk;
    } wr_t;

    wr_t exp_q[$];
    int  exp_done = 0;
    int  n_cmp = 0;
    int  n_err = 0;

    // Device model: data follows the offset combinationally.
    assign dev_data = storage[dev_offset];

    dma_controller dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .dev_interrupt(dev_interrupt),
        .dev_offset   (dev_offset),
        .dev_data     (dev_data),
        .dma_req      (dma_req),
        .cmd_valid    (cmd_valid),
        .cmd_addr     (cmd_addr),
        .cmd_ready    (cmd_ready),
        .br           (br),
        .bg           (bg),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .mem_write    (mem_write),
        .dma_done     (dma_done)
    );

    always #5 if (clk_en) clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: each chunk c lands at base+4c for 4 cycles; a grant loss on
    // overall write number j replays the chunk it hit, after the cycles already spent.
    function automatic int model_push(input logic [15:0] base, input int steal_j);
        int  sc   = (steal_j > 0) ? (steal_j - 1) / 4 : -1;
        int  part = (steal_j > 0) ? ((steal_j - 1) % 4) + 1 : 0;
        int  total = 0;
        wr_t e;
        for (int c = 0; c < 3; c++) begin
            int reps = 4 + ((c == sc) ? part : 0);
            for (int r = 0; r < reps; r++) begin
                e.addr  = base + 16'(4 * c);
                e.data  = storage[c];
                e.chunk = 2'(c);
                exp_q.push_back(e);
                total++;
            end
        end
        exp_done++;
        return total;
    endfunction

    // Monitor: every observed write / completion is matched against the scoreboard.
    always @(negedge clk) begin
        if (reset_n) begin
            if (mem_write === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_write: got addr %h data %h required none", mem_addr, mem_data);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("mem_addr", 64'(mem_addr), 64'(e.addr));
                    check("mem_data", mem_data, e.data);
                    check("dev_offset", 64'(dev_offset), 64'(e.chunk));
                    $display("write addr=%h data=%h chunk=%0d", mem_addr, mem_data, dev_offset);
                end
            end
            if (dma_done === 1'b1) begin
                n_cmp++;
                if (exp_done == 0) begin
                    n_err++;
                    $display("FAIL unexpected_done: got dma_done=1 required 0");
                end else begin
                    exp_done--;
                    $display("done pulse");
                end
            end
        end
    end

    task automatic do_transfer(input logic [15:0] addr, input int steal_j, input int steal_len,
                               input bit retoggle, input int abort_at, input int bg_delay);
        int wcount = 0;
        int total;
        bit stolen = 1'b0;
        bit done = 1'b0;
        for (int i = 0; i < 3; i++) storage[i] = {$urandom, $urandom};
        $display("xfer addr=%h steal=%0d/%0d retoggle=%0d abort=%0d bgdly=%0d",
                 addr, steal_j, steal_len, retoggle, abort_at, bg_delay);
        @(negedge clk);
        dev_interrupt = 1'b1;
        @(negedge clk);
        check("req_latency", 64'(dma_req), 64'd1);
        check("cmd_ready", 64'(cmd_ready), 64'd1);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        cmd_valid = 1'b1;
        cmd_addr  = addr;
        total = model_push(addr, steal_j);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("br_latency", 64'(br), 64'd1);
        check("req_clear", 64'(dma_req), 64'd0);
        repeat (bg_delay) begin
            @(negedge clk);
            check("no_early_write", 64'(mem_write === 1'b1), 64'd0);
        end
        bg = 1'b1;
        for (int cyc = 0; cyc < 300 && !done; cyc++) begin
            @(negedge clk);
            if (mem_write === 1'b1) wcount++;
            cmd_valid = ($urandom_range(0, 7) == 0);
            cmd_addr  = 16'($urandom);
            if (dma_done === 1'b1) begin
                done = 1'b1;
                check("br_drop", 64'(br), 64'd0);
            end else if (mem_write === 1'b1 && wcount == abort_at) begin
                #2 reset_n = 1'b0;
                #1;
                check("abort_br", 64'(br), 64'd0);
                check("abort_req", 64'(dma_req), 64'd0);
                check("abort_done", 64'(dma_done), 64'd0);
                check("abort_offset", 64'(dev_offset), 64'd3);
                check("abort_mem_write", 64'(mem_write === 1'b1), 64'd0);
                exp_q.delete();
                exp_done  = 0;
                bg        = 1'b0;
                cmd_valid = 1'b0;
                dev_interrupt = 1'b0;
                repeat (2) @(posedge clk);
                #1 check("abort_hold_done", 64'(dma_done), 64'd0);
                reset_n = 1'b1;
                @(negedge clk);
                check("abort_idle_br", 64'(br), 64'd0);
                check("abort_idle_req", 64'(dma_req), 64'd0);
                return;
            end else if (mem_write === 1'b1 && wcount == steal_j && !stolen) begin
                stolen    = 1'b1;
                cmd_valid = 1'b0;
                bg        = 1'b0;
                repeat (steal_len) begin
                    @(negedge clk);
                    check("steal_br", 64'(br), 64'd1);
                    check("steal_no_write", 64'(mem_write === 1'b1), 64'd0);
                end
                bg = 1'b1;
            end
            if (retoggle && wcount == 2) dev_interrupt = 1'b0;
            if (retoggle && wcount == 3) dev_interrupt = 1'b1;
        end
        cmd_valid = 1'b0;
        bg = 1'b0;
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL done_timeout: got no dma_done required one within 300 cycles");
        end
        check("write_count", 64'(wcount), 64'(total));
        repeat (4) begin
            @(negedge clk);
            check("no_rereq", 64'(dma_req), 64'd0);
        end
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        check("done_count", 64'(exp_done), 64'd0);
        dev_interrupt = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) storage[i] = {$urandom, $urandom};
        // Reset with the clock stopped.
        #1 reset_n = 1'b0;
        #2;
        check("rst_offset", 64'(dev_offset), 64'd3);
        check("rst_req", 64'(dma_req), 64'd0);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        check("rst_br", 64'(br), 64'd0);
        check("rst_done", 64'(dma_done), 64'd0);
        check("rst_mem_write", 64'(mem_write === 1'b1), 64'd0);
        clk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // Command while idle must be ignored.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_addr  = 16'h1234;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("idle_cmd_br", 64'(br), 64'd0);
        check("idle_cmd_req", 64'(dma_req), 64'd0);
        @(negedge clk);
        check("idle_cmd_br2", 64'(br), 64'd0);

        do_transfer(16'h01F4, 0, 0, 1'b0, 0, 0);   // basic
        do_transfer(16'h01F4, 6, 5, 1'b0, 0, 0);   // steal chunk 1, cycle 2
        do_transfer(16'hFFFC, 0, 0, 1'b0, 0, 1);   // address wrap
        do_transfer(16'h0100, 0, 0, 1'b1, 0, 0);   // second rise during WRITE
        do_transfer(16'h0200, 12, 2, 1'b0, 0, 2);  // grant loss on final cycle
        do_transfer(16'h0300, 0, 0, 1'b0, 7, 0);   // reset mid-WRITE
        do_transfer(16'h0400, 0, 0, 1'b0, 0, 0);   // recovers after reset

        for (int t = 0; t < 30; t++) begin
            int sj = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 12)) : 0;
            int ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 12)) : 0;
            do_transfer(16'($urandom), sj, int'($urandom_range(1, 6)),
                        1'($urandom_range(0, 1)), ab, int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running required finish");
        $fatal(1, "watchdog expired");
    end

endmodule
